// File: rtl/addernet_kernel_ctrl.sv
// AdderNet L1 kernel sequencer: streams len chunks from the buffers through the Kernel
// array, accumulates the lane sums and returns the negated, saturated L1 distance.
module addernet_kernel_ctrl #(
   parameter int NBIT   = 8,
   parameter int NDATA  = 4,
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 8,
   parameter int ACC_W  = 24
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic [ADDR_W-1:0]       i_if_base,
   input  logic [ADDR_W-1:0]       i_w_base,
   input  logic [LEN_W-1:0]        i_len,
   output logic                    o_busy,
   output logic                    o_rd_en,
   output logic [ADDR_W-1:0]       o_if_addr,
   output logic [ADDR_W-1:0]       o_w_addr,
   input  logic [NBIT*NDATA-1:0]   i_if_data,
   input  logic [NBIT*NDATA-1:0]   i_w_data,
   output logic [NBIT*NDATA-1:0]   o_k_if,
   output logic [NBIT*NDATA-1:0]   o_k_w,
   input  logic [NBIT*NDATA-1:0]   i_k_r,
   output logic [ACC_W-1:0]        o_result,
   output logic                    o_valid,
   input  logic                    i_ready
);

   localparam int LSUM_W = NBIT + $clog2(NDATA);
   localparam int WIDE_W = ACC_W + LSUM_W;
   localparam logic [WIDE_W-1:0] ACC_MAX = {{(LSUM_W+1){1'b0}}, {(ACC_W-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

   state_t                  r_state;
   state_t                  w_stateNext;
   logic                    w_rdEn;
   logic [ADDR_W-1:0]       r_ifBase;
   logic [ADDR_W-1:0]       r_wBase;
   logic [LEN_W-1:0]        r_len;
   logic [LEN_W-1:0]        r_cnt;
   logic                    r_drainCnt;
   logic [1:0]              r_vld;
   logic [NBIT*NDATA-1:0]   r_kIf;
   logic [NBIT*NDATA-1:0]   r_kW;
   logic [ACC_W-1:0]        r_acc;
   logic [LSUM_W-1:0]       w_laneSum;
   logic [WIDE_W-1:0]       w_accSum;
   logic [ACC_W-1:0]        w_accNext;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      w_rdEn      = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               if (i_len == '0) w_stateNext = OUT;
               else             w_stateNext = FETCH;
            end
         end
         FETCH: begin
            w_rdEn = 1'b1;
            if (r_cnt == r_len - LEN_W'(1)) w_stateNext = DRAIN;
         end
         DRAIN: begin
            if (r_drainCnt) w_stateNext = OUT;
         end
         OUT: begin
            if (i_ready) w_stateNext = IDLE;
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // Exact lane reduction, then a saturating add that never exceeds the largest positive result.
   always_comb begin
      w_laneSum = '0;
      for (int i = 0; i < NDATA; i++) begin
         w_laneSum = w_laneSum + LSUM_W'(i_k_r[i*NBIT +: NBIT]);
      end
      w_accSum  = WIDE_W'(r_acc) + WIDE_W'(w_laneSum);
      w_accNext = (w_accSum > ACC_MAX) ? ACC_MAX[ACC_W-1:0] : w_accSum[ACC_W-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ifBase   <= '0;
         r_wBase    <= '0;
         r_len      <= '0;
         r_cnt      <= '0;
         r_drainCnt <= 1'b0;
         r_vld      <= '0;
         r_kIf      <= '0;
         r_kW       <= '0;
         r_acc      <= '0;
      end else begin
         r_vld <= {r_vld[0], w_rdEn};
         if (r_vld[0]) begin
            r_kIf <= i_if_data;
            r_kW  <= i_w_data;
         end
         if (r_state == IDLE && i_start) begin
            r_ifBase <= i_if_base;
            r_wBase  <= i_w_base;
            r_len    <= i_len;
            r_cnt    <= '0;
            r_acc    <= '0;
         end else if (r_vld[1]) begin
            r_acc <= w_accNext;
         end
         if (r_state == FETCH) r_cnt <= r_cnt + LEN_W'(1);
         if (r_state == DRAIN) r_drainCnt <= ~r_drainCnt;
         else                  r_drainCnt <= 1'b0;
      end
   end

   assign o_busy    = (r_state != IDLE);
   assign o_valid   = (r_state == OUT);
   assign o_rd_en   = w_rdEn;
   assign o_if_addr = r_ifBase + ADDR_W'(r_cnt);
   assign o_w_addr  = r_wBase + ADDR_W'(r_cnt);
   assign o_k_if    = r_kIf;
   assign o_k_w     = r_kW;
   assign o_result  = '0 - r_acc;

endmodule

// File: tb/tb_addernet_kernel_ctrl.sv
// Directed bench for addernet_kernel_ctrl: a wide-accumulator instance plus a
// 10-bit-accumulator instance sharing one stimulus stream and buffer model.
module tb_addernet_kernel_ctrl;

   localparam int NBIT  = 8;
   localparam int NDATA = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  ifBase;
   logic [7:0]  wBase;
   logic [7:0]  len;
   logic [31:0] ifData;
   logic [31:0] wData;
   logic        ready;

   logic        busy, rdEn, valid;
   logic [7:0]  ifAddr, wAddr;
   logic [31:0] kIf, kW, kR;
   logic [23:0] result;

   logic        satBusy, satRdEn, satValid;
   logic [7:0]  satIfAddr, satWAddr;
   logic [31:0] satKIf, satKW, satKR;
   logic [9:0]  satResult;

   logic [31:0] ifMem [256];
   logic [31:0] wMem  [256];

   int passCnt  = 0;
   int checkCnt = 0;

   addernet_kernel_ctrl #(.NBIT(NBIT), .NDATA(NDATA), .ADDR_W(8), .LEN_W(8), .ACC_W(24)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_if_base(ifBase), .i_w_base(wBase),
      .i_len(len), .o_busy(busy), .o_rd_en(rdEn), .o_if_addr(ifAddr), .o_w_addr(wAddr),
      .i_if_data(ifData), .i_w_data(wData), .o_k_if(kIf), .o_k_w(kW), .i_k_r(kR),
      .o_result(result), .o_valid(valid), .i_ready(ready)
   );

   addernet_kernel_ctrl #(.NBIT(NBIT), .NDATA(NDATA), .ADDR_W(8), .LEN_W(8), .ACC_W(10)) dutSat (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_if_base(ifBase), .i_w_base(wBase),
      .i_len(len), .o_busy(satBusy), .o_rd_en(satRdEn), .o_if_addr(satIfAddr), .o_w_addr(satWAddr),
      .i_if_data(ifData), .i_w_data(wData), .o_k_if(satKIf), .o_k_w(satKW), .i_k_r(satKR),
      .o_result(satResult), .o_valid(satValid), .i_ready(ready)
   );

   // Behavioural Kernel array: per-lane unsigned |x - w|.
   function automatic logic [31:0] absDiffVec(input logic [31:0] x, input logic [31:0] w);
      logic [31:0] r;
      logic [7:0]  a;
      logic [7:0]  b;
      r = '0;
      for (int i = 0; i < NDATA; i++) begin
         a = x[i*8 +: 8];
         b = w[i*8 +: 8];
         r[i*8 +: 8] = (a > b) ? (a - b) : (b - a);
      end
      return r;
   endfunction

   assign kR    = absDiffVec(kIf, kW);
   assign satKR = absDiffVec(satKIf, satKW);

   // Synchronous-read buffers: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (rdEn) begin
         ifData <= ifMem[ifAddr];
         wData  <= wMem[wAddr];
      end
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic [7:0] ib, input logic [7:0] wb,
                                input logic [7:0] ln, input logic rdy);
      start  = s;
      ifBase = ib;
      wBase  = wb;
      len    = ln;
      ready  = rdy;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCnt++;
      assert (obs === exp) passCnt++;
      else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 8'h00, 8'd0, 1'b0);
      for (int i = 0; i < 256; i++) begin
         ifMem[i] = '0;
         wMem[i]  = '0;
      end
      tick();
      tick();
      checkOutput("rst_busy",   {31'd0, busy},   32'd0);
      checkOutput("rst_rd_en",  {31'd0, rdEn},   32'd0);
      checkOutput("rst_if_addr", {24'd0, ifAddr}, 32'd0);
      checkOutput("rst_w_addr", {24'd0, wAddr},  32'd0);
      checkOutput("rst_k_if",   kIf,             32'd0);
      checkOutput("rst_k_w",    kW,              32'd0);
      checkOutput("rst_result", {8'd0, result},  32'd0);
      checkOutput("rst_valid",  {31'd0, valid},  32'd0);
      rst = 1'b0;
      tick();

      // len=2, features 10, weights 3: 4 lanes * 7 * 2 chunks = 56
      ifMem[8'h10] = {4{8'd10}};
      ifMem[8'h11] = {4{8'd10}};
      wMem[8'h40]  = {4{8'd3}};
      wMem[8'h41]  = {4{8'd3}};
      applyStimulus(1'b1, 8'h10, 8'h40, 8'd2, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h10, 8'h40, 8'd2, 1'b0);
      checkOutput("t1_c1_rd_en",   {31'd0, rdEn},   32'd1);
      checkOutput("t1_c1_busy",    {31'd0, busy},   32'd1);
      checkOutput("t1_c1_if_addr", {24'd0, ifAddr}, 32'h10);
      checkOutput("t1_c1_w_addr",  {24'd0, wAddr},  32'h40);
      tick();
      checkOutput("t1_c2_rd_en",   {31'd0, rdEn},   32'd1);
      checkOutput("t1_c2_if_addr", {24'd0, ifAddr}, 32'h11);
      checkOutput("t1_c2_w_addr",  {24'd0, wAddr},  32'h41);
      tick();
      checkOutput("t1_c3_rd_en",   {31'd0, rdEn},   32'd0);
      checkOutput("t1_c3_k_if",    kIf,             {4{8'd10}});
      checkOutput("t1_c3_k_w",     kW,              {4{8'd3}});
      tick();
      checkOutput("t1_c4_valid",   {31'd0, valid},  32'd0);
      checkOutput("t1_c4_busy",    {31'd0, busy},   32'd1);
      tick();
      checkOutput("t1_c5_valid",   {31'd0, valid},  32'd1);
      checkOutput("t1_c5_result",  {8'd0, result},  32'h00FFFFC8);
      checkOutput("t1_c5_sat_res", {22'd0, satResult}, 32'h3C8);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checkOutput("t1_idle_busy",  {31'd0, busy},   32'd0);
      checkOutput("t1_idle_valid", {31'd0, valid},  32'd0);

      // len=0: immediate zero result, no read strobe
      applyStimulus(1'b1, 8'h10, 8'h40, 8'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h10, 8'h40, 8'd0, 1'b0);
      checkOutput("t2_valid",  {31'd0, valid},  32'd1);
      checkOutput("t2_result", {8'd0, result},  32'd0);
      checkOutput("t2_rd_en",  {31'd0, rdEn},   32'd0);
      checkOutput("t2_busy",   {31'd0, busy},   32'd1);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checkOutput("t2_idle_busy", {31'd0, busy}, 32'd0);

      // address wrap from 0xFE; lane diffs 15,25,35 -> 4*(75) = 300
      ifMem[8'hFE] = {4{8'd20}};
      ifMem[8'hFF] = {4{8'd30}};
      ifMem[8'h00] = {4{8'd40}};
      wMem[8'h80]  = {4{8'd5}};
      wMem[8'h81]  = {4{8'd5}};
      wMem[8'h82]  = {4{8'd5}};
      applyStimulus(1'b1, 8'hFE, 8'h80, 8'd3, 1'b0);
      tick();
      applyStimulus(1'b0, 8'hFE, 8'h80, 8'd3, 1'b0);
      checkOutput("t3_c1_if_addr", {24'd0, ifAddr}, 32'hFE);
      tick();
      checkOutput("t3_c2_if_addr", {24'd0, ifAddr}, 32'hFF);
      tick();
      checkOutput("t3_c3_if_addr", {24'd0, ifAddr}, 32'h00);
      checkOutput("t3_c3_w_addr",  {24'd0, wAddr},  32'h82);
      checkOutput("t3_c3_rd_en",   {31'd0, rdEn},   32'd1);
      tick();
      checkOutput("t3_c4_rd_en",   {31'd0, rdEn},   32'd0);
      tick();
      checkOutput("t3_c5_valid",   {31'd0, valid},  32'd0);
      tick();
      checkOutput("t3_sat_res",    {22'd0, satResult}, 32'h2D4);
      for (int c = 0; c < 4; c++) begin
         checkOutput("t3_hold_valid",  {31'd0, valid}, 32'd1);
         checkOutput("t3_hold_result", {8'd0, result}, 32'h00FFFED4);
         tick();
      end
      checkOutput("t3_last_valid", {31'd0, valid}, 32'd1);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checkOutput("t3_idle_busy",  {31'd0, busy},  32'd0);

      // saturation: lane sums 1020 each; 10-bit accumulator clamps at 511
      ifMem[8'h20] = 32'hFFFF_FFFF;
      ifMem[8'h21] = 32'hFFFF_FFFF;
      wMem[8'h60]  = 32'd0;
      wMem[8'h61]  = 32'd0;
      applyStimulus(1'b1, 8'h20, 8'h60, 8'd2, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h20, 8'h60, 8'd2, 1'b0);
      for (int c = 0; c < 4; c++) tick();
      checkOutput("t4_sat_valid",  {31'd0, satValid}, 32'd1);
      checkOutput("t4_sat_result", {22'd0, satResult}, 32'h201);
      checkOutput("t4_wide_result", {8'd0, result}, 32'h00FFF808);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checkOutput("t4_sat_idle", {31'd0, satBusy}, 32'd0);

      // starts during FETCH and in the handshake cycle are ignored
      applyStimulus(1'b1, 8'h10, 8'h40, 8'd2, 1'b0);
      tick();
      applyStimulus(1'b1, 8'h20, 8'h60, 8'd7, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h20, 8'h60, 8'd7, 1'b0);
      checkOutput("t5_latched_if", {24'd0, ifAddr}, 32'h11);
      checkOutput("t5_latched_w",  {24'd0, wAddr},  32'h41);
      tick();
      tick();
      tick();
      checkOutput("t5_valid",  {31'd0, valid}, 32'd1);
      checkOutput("t5_result", {8'd0, result}, 32'h00FFFFC8);
      applyStimulus(1'b1, 8'h20, 8'h60, 8'd0, 1'b1);
      tick();
      checkOutput("t5_hs_start_busy",  {31'd0, busy},  32'd0);
      checkOutput("t5_hs_start_valid", {31'd0, valid}, 32'd0);
      applyStimulus(1'b1, 8'h20, 8'h60, 8'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h20, 8'h60, 8'd0, 1'b0);
      checkOutput("t5_next_valid",  {31'd0, valid}, 32'd1);
      checkOutput("t5_next_result", {8'd0, result}, 32'd0);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checkOutput("t5_idle_busy", {31'd0, busy}, 32'd0);

      // reset in cycle 2 of a len=5 job, then a clean rerun: 4*10*5 = 200
      for (int i = 0; i < 5; i++) begin
         ifMem[8'h30 + i] = {4{8'd50}};
         wMem[8'h70 + i]  = {4{8'd60}};
      end
      applyStimulus(1'b1, 8'h30, 8'h70, 8'd5, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h30, 8'h70, 8'd5, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("t6_rst_busy",    {31'd0, busy},   32'd0);
      checkOutput("t6_rst_rd_en",   {31'd0, rdEn},   32'd0);
      checkOutput("t6_rst_if_addr", {24'd0, ifAddr}, 32'd0);
      checkOutput("t6_rst_w_addr",  {24'd0, wAddr},  32'd0);
      checkOutput("t6_rst_k_if",    kIf,             32'd0);
      checkOutput("t6_rst_k_w",     kW,              32'd0);
      checkOutput("t6_rst_result",  {8'd0, result},  32'd0);
      checkOutput("t6_rst_valid",   {31'd0, valid},  32'd0);
      rst = 1'b0;
      tick();
      applyStimulus(1'b1, 8'h30, 8'h70, 8'd5, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h30, 8'h70, 8'd5, 1'b0);
      for (int c = 0; c < 6; c++) tick();
      checkOutput("t6_c7_valid",  {31'd0, valid}, 32'd0);
      tick();
      checkOutput("t6_c8_valid",  {31'd0, valid}, 32'd1);
      checkOutput("t6_result",    {8'd0, result}, 32'h00FFFF38);
      checkOutput("t6_sat_result", {22'd0, satResult}, 32'h338);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checkOutput("t6_idle_busy", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
